// File: rtl/bcd_add_sequencer_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM encoding, BCD constants
// and a digit validity helper.
package bcd_add_sequencer_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_ADJ = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Plain-vector encodings of the states for legacy code that keeps state as logic.
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_add_sequencer_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
module bcd_digit_add
    import bcd_add_sequencer_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               c,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    logic [DIGIT_W:0] raw;
    logic [DIGIT_W:0] adj;

    // Invalid input digits still go through the same correction; the 5-bit sum wraps mod 32.
    always_comb begin
        raw = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, c};
        adj = raw;
        if (raw > {1'b0, BCD_MAX}) begin
            adj = raw + {1'b0, BCD_ADJ};
        end
        digit = adj[DIGIT_W-1:0];
        carry = adj[DIGIT_W];
    end

endmodule

// File: rtl/bcd_add_sequencer.sv
// Digit-serial BCD adder: latches operands on start, adds one digit per cycle
// through a single digit adder, then pulses done for one cycle.
module bcd_add_sequencer
    import bcd_add_sequencer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DIGIT_W*DIGITS-1:0]   a,
    input  logic [DIGIT_W*DIGITS-1:0]   b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   sum,
    output logic                        cout,
    output logic                        err
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [1:0]         state;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [IDX_W-1:0]   index;
    logic               carry;
    logic [DIGIT_W-1:0] digit;
    logic               digit_carry;
    logic               in_err;

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(a[i*DIGIT_W +: DIGIT_W]) || digit_invalid(b[i*DIGIT_W +: DIGIT_W])) begin
                in_err = 1'b1;
            end
        end
    end

    // Operands shift right each RUN cycle so the current digit is always the low nibble.
    bcd_digit_add u_digit_add (
        .a_d   (a_sh[DIGIT_W-1:0]),
        .b_d   (b_sh[DIGIT_W-1:0]),
        .c     (carry),
        .digit (digit),
        .carry (digit_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            index <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        index <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= in_err;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[index*DIGIT_W +: DIGIT_W] <= digit;
                    carry <= digit_carry;
                    a_sh  <= a_sh >> DIGIT_W;
                    b_sh  <= b_sh >> DIGIT_W;
                    if (index == LAST_IDX) begin
                        index <= '0;
                        cout  <= digit_carry;
                        state <= ST_DONE;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Directed self-checking bench for bcd_add_sequencer (DIGITS=4); inputs change
// and outputs are sampled 1ns after each rising edge.
module tb_bcd_add_sequencer;

    localparam int DIGITS = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int passed = 0;
    int total  = 0;
    int cycle  = 0;

    bcd_add_sequencer #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] av, input logic [15:0] bv, input logic ci);
        start = s;
        a     = av;
        b     = bv;
        cin   = ci;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One complete operation with start pulsed for a single cycle; operands are
    // scrambled right after accept to show they no longer matter.
    task automatic runOp(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic [15:0] exp_sum, input logic exp_cout, input logic exp_err);
        logic early;
        applyStimulus(1'b1, av, bv, ci);
        step();
        applyStimulus(1'b0, 16'hFFFF, 16'hAAAA, ~ci);
        checkOutput({tag, " busy after accept"}, 16'(busy), 16'd1);
        checkOutput({tag, " sum cleared"}, sum, 16'h0000);
        checkOutput({tag, " err at accept"}, 16'(err), 16'(exp_err));
        early = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            step();
            if (done !== 1'b0) early = 1'b1;
        end
        checkOutput({tag, " no early done"}, 16'(early), 16'd0);
        step();
        checkOutput({tag, " done"}, 16'(done), 16'd1);
        checkOutput({tag, " sum"}, sum, exp_sum);
        checkOutput({tag, " cout"}, 16'(cout), 16'(exp_cout));
        checkOutput({tag, " err"}, 16'(err), 16'(exp_err));
        step();
        checkOutput({tag, " done one cycle"}, 16'(done), 16'd0);
        checkOutput({tag, " idle busy"}, 16'(busy), 16'd0);
    endtask

    // Steps until done is seen or the budget expires; returns the cycle stamp or -1.
    task automatic waitDone(input int budget, output int stamp);
        stamp = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done === 1'b1) begin
                stamp = cycle;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   c_acc;
        int   c_d1;
        int   c_d2;
        logic seen;

        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        step();
        checkOutput("reset busy", 16'(busy), 16'd0);
        checkOutput("reset done", 16'(done), 16'd0);
        checkOutput("reset sum", sum, 16'h0000);
        checkOutput("reset cout", 16'(cout), 16'd0);
        checkOutput("reset err", 16'(err), 16'd0);
        rst = 1'b0;
        step();
        checkOutput("idle busy", 16'(busy), 16'd0);

        runOp("1234+5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        runOp("9999+0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        runOp("9999+9999+1", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

        runOp("00A0+0000", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        checkOutput("err held idle", 16'(err), 16'd1);
        checkOutput("sum held idle", sum, 16'h0100);
        runOp("0505+0494", 16'h0505, 16'h0494, 1'b0, 16'h0999, 1'b0, 1'b0);

        // Start held high throughout, with operands changing during RUN/DONE.
        applyStimulus(1'b1, 16'h0005, 16'h0005, 1'b0);
        step();
        c_acc = cycle;
        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0);
        checkOutput("hold busy", 16'(busy), 16'd1);
        waitDone(12, c_d1);
        checkOutput("hold first latency", 16'(c_d1 - c_acc), 16'(DIGITS));
        checkOutput("hold first sum", sum, 16'h0010);
        checkOutput("hold first cout", 16'(cout), 16'd0);
        step();
        checkOutput("hold ignored on done edge", 16'(busy), 16'd0);
        checkOutput("hold sum kept", sum, 16'h0010);
        step();
        checkOutput("hold reaccept busy", 16'(busy), 16'd1);
        checkOutput("hold reaccept sum clr", sum, 16'h0000);
        waitDone(12, c_d2);
        checkOutput("hold done spacing", 16'(c_d2 - c_d1), 16'(DIGITS + 2));
        checkOutput("hold second sum", sum, 16'h3333);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        step();
        checkOutput("hold end idle", 16'(busy), 16'd0);

        // Reset during the second RUN cycle aborts the operation.
        applyStimulus(1'b1, 16'h1234, 16'h5678, 1'b0);
        step();
        applyStimulus(1'b0, 16'h1234, 16'h5678, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrun rst busy", 16'(busy), 16'd0);
        checkOutput("midrun rst sum", sum, 16'h0000);
        checkOutput("midrun rst cout", 16'(cout), 16'd0);
        checkOutput("midrun rst done", 16'(done), 16'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done !== 1'b0) seen = 1'b1;
        end
        checkOutput("midrun no done pulse", 16'(seen), 16'd0);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        applyStimulus(1'b1, 16'h1111, 16'h1111, 1'b0);
        step();
        rst = 1'b0;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("rst over start", 16'(busy), 16'd0);

        runOp("4321+1111", 16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0);
        runOp("0000+0000+1", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
